mem_fill_arbiter: RTL and testbench

//  Shares the single multi-cycle main memory between the I-cache miss path and the
//  D-cache miss/write-through path of the pipelined CPU. Grants one requester at a

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_cnt.sv | 29 ++
 rtl/mem_fill_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the cache-fill memory arbiter.
// Ports: none (package).
package mem_arb_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int BLK_WDS   = 8;
  localparam int BLK_IDX_W = 3;
  localparam int MEM_LAT   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arb_cnt.sv
// Block word counter: counts 0..BLK_WDS-1 and wraps.
// Ports: clk_i, rst_i, en_i (count), clr_i (to 0), cnt_o, wrap_o (at last word).
module mem_arb_cnt
  import mem_arb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  output logic [BLK_IDX_W-1:0] cnt_o,
  output logic                 wrap_o
);

  logic [BLK_IDX_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == BLK_IDX_W'(BLK_WDS - 1));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D cache misses onto one memory, sequences block fills,
// steers returns to the owner and issues D-side single-word writes.
// Ports: clk, rst; i_req/i_addr; d_req/d_wr/d_addr/d_wdata; mem_* memory
// side; fill_data/fill_word/i_fill_vld/d_fill_vld; i_done/d_done; busy.
module mem_fill_arbiter
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic                 d_req,
  input  logic                 d_wr,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_rvalid,
  output logic [DATA_W-1:0]    fill_data,
  output logic [BLK_IDX_W-1:0] fill_word,
  output logic                 i_fill_vld,
  output logic                 d_fill_vld,
  output logic                 i_done,
  output logic                 d_done,
  output logic                 busy
);

  state_e              state_q;
  owner_e              owner_q;
  owner_e              last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [BLK_IDX_W-1:0] iss_cnt;
  logic [BLK_IDX_W-1:0] rx_cnt;
  logic                 iss_wrap;
  logic                 rx_wrap;

  logic issuing;
  logic writing;
  logic filling;
  logic last_rx;
  logic gnt_i;
  logic gnt_d;

  assign issuing = (state_q == ISSUE);
  assign writing = (state_q == WRITE);
  // Returns outside a fill (e.g. stale after reset) are dropped here.
  assign filling = mem_rvalid &&
                   (state_q == ISSUE || state_q == DRAIN);
  assign last_rx = filling && rx_wrap;

  // Round-robin on a tie: the side that did not go last wins.
  assign gnt_d = d_req && (!i_req || last_q == OWN_I);
  assign gnt_i = i_req && !gnt_d;

  mem_arb_cnt u_iss_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (issuing),
    .clr_i  (state_q == IDLE),
    .cnt_o  (iss_cnt),
    .wrap_o (iss_wrap)
  );

  mem_arb_cnt u_rx_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (filling),
    .clr_i  (last_rx || state_q == IDLE),
    .cnt_o  (rx_cnt),
    .wrap_o (rx_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= NONE;
      last_q  <= OWN_I;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_d) begin
            owner_q <= OWN_D;
            last_q  <= OWN_D;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            state_q <= d_wr ? WRITE : ISSUE;
          end else if (gnt_i) begin
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            addr_q  <= i_addr;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (last_rx) begin
            owner_q <= NONE;
            state_q <= IDLE;
          end else if (iss_wrap) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_rx) begin
            owner_q <= NONE;
            state_q <= IDLE;
          end
        end
        WRITE: begin
          owner_q <= NONE;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    if (issuing) begin
      mem_addr = {addr_q[ADDR_W-1:4], iss_cnt, 1'b0};
    end else if (writing) begin
      mem_addr = addr_q;
    end
  end

  assign mem_en    = issuing || writing;
  assign mem_wr    = writing;
  assign mem_wdata = writing ? wdata_q : '0;

  assign fill_data  = mem_rdata;
  assign fill_word  = filling ? rx_cnt : '0;
  assign i_fill_vld = filling && (owner_q == OWN_I);
  assign d_fill_vld = filling && (owner_q == OWN_D);
  assign i_done     = last_rx && (owner_q == OWN_I);
  assign d_done     = (last_rx && (owner_q == OWN_D)) || writing;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: memory model, cycle compare against a
// transaction-level model, and directed scenarios with literal checks.
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [2:0]  fill_word;
  logic        i_fill_vld, d_fill_vld, i_done, d_done, busy;

  mem_fill_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .fill_data  (fill_data),
    .fill_word  (fill_word),
    .i_fill_vld (i_fill_vld),
    .d_fill_vld (d_fill_vld),
    .i_done     (i_done),
    .d_done     (d_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory read history: {read issued, address} per cycle.
  logic [16:0] hist [0:8191];
  int cyc = 0;

  // Transaction-level model state.
  bit          m_busy = 0;
  bit          m_wr = 0;
  int          m_own = 0;
  int          m_last = 1;
  int          m_iss = 0;
  int          m_rx = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wd = '0;

  // Event logs for the directed scenarios.
  int          n_idone = 0;
  int          n_ddone = 0;
  int          done_q[$];
  int          done_cyc[$];
  logic [15:0] iss_q[$];
  int          iss_cyc[$];
  int          fill_q[$];
  logic [31:0] wr_q[$];
  int          wr_cyc[$];

  always @(negedge clk) begin
    logic        e_en, e_wr, e_ifv, e_dfv, e_id, e_dd;
    logic [15:0] e_addr, e_wd;
    logic [2:0]  e_fw;
    if (rst) begin
      chk("reset_outs",
          32'({mem_en, mem_wr, mem_addr != 16'h0,
               mem_wdata != 16'h0, fill_word, i_fill_vld,
               d_fill_vld, i_done, d_done, busy}),
          32'h0);
      m_busy = 0;
      m_own  = 0;
      m_last = 1;
      m_iss  = 0;
      m_rx   = 0;
      hist[cyc % 8192] = 17'h0;
    end else begin
      e_en = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      e_ifv = 0; e_dfv = 0; e_fw = '0; e_id = 0; e_dd = 0;
      if (m_busy && m_wr) begin
        e_en = 1; e_wr = 1; e_addr = m_addr;
        e_wd = m_wd; e_dd = 1;
      end else if (m_busy) begin
        if (m_iss < 8) begin
          e_en   = 1;
          e_addr = {m_addr[15:4], 4'h0} + 16'(2 * m_iss);
        end
        if (mem_rvalid) begin
          e_fw = 3'(m_rx);
          if (m_own == 1) e_ifv = 1;
          else            e_dfv = 1;
          if (m_rx == 7) begin
            if (m_own == 1) e_id = 1;
            else            e_dd = 1;
          end
        end
      end
      chk("busy",       32'(busy),       32'(m_busy));
      chk("mem_en",     32'(mem_en),     32'(e_en));
      chk("mem_wr",     32'(mem_wr),     32'(e_wr));
      chk("mem_addr",   32'(mem_addr),   32'(e_addr));
      chk("mem_wdata",  32'(mem_wdata),  32'(e_wd));
      chk("fill_data",  32'(fill_data),  32'(mem_rdata));
      chk("fill_word",  32'(fill_word),  32'(e_fw));
      chk("i_fill_vld", 32'(i_fill_vld), 32'(e_ifv));
      chk("d_fill_vld", 32'(d_fill_vld), 32'(e_dfv));
      chk("i_done",     32'(i_done),     32'(e_id));
      chk("d_done",     32'(d_done),     32'(e_dd));

      if (i_done) begin
        n_idone++; done_q.push_back(1); done_cyc.push_back(cyc);
      end
      if (d_done) begin
        n_ddone++; done_q.push_back(2); done_cyc.push_back(cyc);
      end
      if (mem_en && !mem_wr) begin
        iss_q.push_back(mem_addr); iss_cyc.push_back(cyc);
      end
      if (mem_en && mem_wr) begin
        wr_q.push_back({mem_addr, mem_wdata}); wr_cyc.push_back(cyc);
      end
      if (i_fill_vld) fill_q.push_back(8 + int'(fill_word));
      if (d_fill_vld) fill_q.push_back(16 + int'(fill_word));
      hist[cyc % 8192] = {mem_en && !mem_wr, mem_addr};

      if (!m_busy) begin
        if (d_req && (!i_req || m_last == 1)) begin
          m_busy = 1; m_own = 2; m_last = 2; m_wr = d_wr;
          m_addr = d_addr; m_wd = d_wdata; m_iss = 0; m_rx = 0;
        end else if (i_req) begin
          m_busy = 1; m_own = 1; m_last = 1; m_wr = 0;
          m_addr = i_addr; m_iss = 0; m_rx = 0;
        end
      end else if (m_wr) begin
        m_busy = 0; m_own = 0;
      end else begin
        if (m_iss < 8) m_iss++;
        if (mem_rvalid) begin
          m_rx++;
          if (m_rx == 8) begin
            m_busy = 0; m_own = 0;
          end
        end
      end
    end
    cyc++;
  end

  bit auto_drop = 1;
  int ack_i = 0;
  int ack_d = 0;

  // One clock: memory returns MEM_LAT cycles after issue, and
  // requesters drop their request the cycle after their done.
  task automatic step();
    logic [16:0] h;
    @(posedge clk);
    #1;
    h = 17'h0;
    if (cyc >= 4) h = hist[(cyc - 4) % 8192];
    if (h[16]) begin
      mem_rvalid = 1'b1;
      mem_rdata  = h[15:0] ^ 16'hA5C3;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
    if (auto_drop && n_idone > ack_i) begin
      i_req = 1'b0; ack_i = n_idone;
    end
    if (auto_drop && n_ddone > ack_d) begin
      d_req = 1'b0; ack_d = n_ddone;
    end
  endtask

  task automatic wait_dones(input int ti, input int td,
                            input int maxc, input string nm);
    int k;
    k = 0;
    while ((n_idone < ti || n_ddone < td) && k < maxc) begin
      step();
      k++;
    end
    chk(nm, 32'(n_idone >= ti && n_ddone >= td), 32'h1);
  endtask

  task automatic clr_logs();
    done_q.delete(); done_cyc.delete();
    iss_q.delete(); iss_cyc.delete();
    fill_q.delete(); wr_q.delete(); wr_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; d_req = 0; d_wr = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_rvalid = 0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_en", 32'(mem_en), 32'h0);

    // 1: lone I miss
    clr_logs();
    i_addr = 16'h0126; i_req = 1; ack_i = n_idone;
    wait_dones(n_idone + 1, n_ddone, 40, "t1_timeout");
    step(); step();
    chk("t1_niss", 32'(iss_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < iss_q.size(); k++)
      chk("t1_addr", 32'(iss_q[k]), 32'(16'h0120 + 16'(2 * k)));
    chk("t1_nfill", 32'(fill_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < fill_q.size(); k++)
      chk("t1_fill", 32'(fill_q[k]), 32'(8 + k));
    chk("t1_ndone", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) chk("t1_side", 32'(done_q[0]), 32'd1);

    // 2: lone D write
    clr_logs();
    d_addr = 16'h4002; d_wdata = 16'hBEEF; d_wr = 1;
    d_req = 1; ack_d = n_ddone;
    wait_dones(n_idone, n_ddone + 1, 20, "t2_timeout");
    step(); step();
    d_wr = 0;
    chk("t2_nwr", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) begin
      chk("t2_wr", wr_q[0], 32'h4002BEEF);
      if (done_cyc.size() > 0)
        chk("t2_done_cyc", 32'(done_cyc[0] - wr_cyc[0]), 32'd0);
    end
    chk("t2_niss", 32'(iss_q.size()), 32'd0);

    // 3: simultaneous after reset, D first then I
    do_reset();
    clr_logs();
    d_addr = 16'h2010; i_addr = 16'h3000; d_wr = 0;
    ack_i = n_idone; ack_d = n_ddone;
    i_req = 1; d_req = 1;
    wait_dones(n_idone + 1, n_ddone + 1, 80, "t3_timeout");
    step(); step();
    chk("t3_ndone", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) begin
      chk("t3_first", 32'(done_q[0]), 32'd2);
      chk("t3_second", 32'(done_q[1]), 32'd1);
    end
    if (iss_q.size() == 16) begin
      chk("t3_d_base", 32'(iss_q[0]), 32'h2010);
      chk("t3_i_base", 32'(iss_q[8]), 32'h3000);
      if (done_cyc.size() > 0)
        chk("t3_gap", 32'(iss_cyc[8] - done_cyc[0]), 32'd2);
    end else begin
      chk("t3_niss", 32'(iss_q.size()), 32'd16);
    end

    // 4: both held for four operations
    clr_logs();
    auto_drop = 0;
    d_addr = 16'h5000; i_addr = 16'h6000;
    i_req = 1; d_req = 1;
    wait_dones(n_idone + 2, n_ddone + 2, 200, "t4_timeout");
    i_req = 0; d_req = 0;
    ack_i = n_idone; ack_d = n_ddone;
    auto_drop = 1;
    step(); step();
    chk("t4_ndone", 32'(done_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < done_q.size(); k++)
      chk("t4_order", 32'(done_q[k]), (k % 2 == 0) ? 32'd2 : 32'd1);

    // 5: reset during issue at word 3
    i_addr = 16'h0700; i_req = 1; ack_i = n_idone;
    begin
      int k;
      k = 0;
      while (!(mem_en && mem_addr == 16'h0706) && k < 30) begin
        step(); k++;
      end
      chk("t5_reach", 32'(k < 30), 32'h1);
    end
    rst = 1'b1;
    i_req = 0;
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_en", 32'(mem_en), 32'h0);
    chk("t5_addr", 32'(mem_addr), 32'h0);
    begin
      int nd;
      nd = n_idone;
      step();
      rst = 1'b0;
      repeat (6) step();
      chk("t5_no_done", 32'(n_idone), 32'(nd));
    end
    clr_logs();
    i_addr = 16'h0230; i_req = 1; ack_i = n_idone;
    wait_dones(n_idone + 1, n_ddone, 40, "t5b_timeout");
    step(); step();
    chk("t5_niss", 32'(iss_q.size()), 32'd8);
    if (iss_q.size() > 0) chk("t5_addr0", 32'(iss_q[0]), 32'h0230);
    for (int k = 0; k < 8 && k < fill_q.size(); k++)
      chk("t5_fill", 32'(fill_q[k]), 32'(8 + k));

    // 6: D fill at top of address space
    clr_logs();
    d_addr = 16'hFFFE; d_wr = 0; d_req = 1; ack_d = n_ddone;
    wait_dones(n_idone, n_ddone + 1, 40, "t6_timeout");
    step(); step();
    chk("t6_niss", 32'(iss_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < iss_q.size(); k++)
      chk("t6_addr", 32'(iss_q[k]), 32'(16'hFFF0 + 16'(2 * k)));
    for (int k = 0; k < 8 && k < fill_q.size(); k++)
      chk("t6_fill", 32'(fill_q[k]), 32'(16 + k));
    chk("t6_ndone", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) chk("t6_side", 32'(done_q[0]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
